la_capture_core: RTL and testbench

LA_CAPTURE_CORE -- requirements
Module: la_capture_core

---
 rtl/la_capture_core.sv | 136 +++++++++++++
 tb/tb_la_capture_core.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_core.sv
// Logic-analyser capture core: circular sample buffer with pre-trigger history,
// mask/value trigger and registered readout. Define LA_EDGE_TRIG_EN for edge-qualified triggering.
module la_capture_core #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     arm_i,
    input  logic                     abort_i,
    input  logic [DATA_W-1:0]        trig_mask_i,
    input  logic [DATA_W-1:0]        trig_value_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     armed_o,
    output logic                     triggered_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH)-1:0] trig_addr_o,
    output logic [$clog2(DEPTH)-1:0] start_addr_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PRE_A     = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG == 0 ? 0 : PRE_TRIG - 1);
    // Offset from the trigger address to the last post-trigger write.
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_TRIG - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   trig_addr_q, trig_addr_d;
    logic [AW-1:0]   start_addr_q, start_addr_d;
    logic            triggered_q, triggered_d;
    logic            wr_en;
    logic            match;
    logic            trig_hit;
    logic [DATA_W-1:0] mem [DEPTH];

    assign match = (((data_i ^ trig_value_i) & trig_mask_i) == '0);

`ifdef LA_EDGE_TRIG_EN
    // Reset to 1 so a signal already matching out of reset is not a rising edge.
    logic prev_match_q;

    always_ff @(posedge clk) begin
        if (rst) prev_match_q <= 1'b1;
        else     prev_match_q <= match;
    end

    assign trig_hit = match & ~prev_match_q;
`else
    assign trig_hit = match;
`endif

    assign wr_en = (state_q == PRE_FILL) || (state_q == WAIT_TRIG) || (state_q == POST);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        triggered_d  = triggered_q;
        if (abort_i) begin
            state_d     = IDLE;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm_i) begin
                        wr_ptr_d    = '0;
                        triggered_d = 1'b0;
                        state_d     = (PRE_TRIG == 0) ? WAIT_TRIG : PRE_FILL;
                    end
                end
                PRE_FILL: begin
                    if (wr_ptr_q == PRE_LAST) state_d = WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    if (trig_hit) begin
                        trig_addr_d  = wr_ptr_q;
                        start_addr_d = wr_ptr_q - PRE_A;
                        triggered_d  = 1'b1;
                        // A one-sample post window is already complete with the trigger write.
                        state_d      = (DEPTH - PRE_TRIG == 1) ? DONE : POST;
                    end
                end
                POST: begin
                    if (wr_ptr_q == trig_addr_q + POST_LAST) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            triggered_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            triggered_q  <= triggered_d;
        end
    end

    // Buffer has no reset; contents survive reset and abort.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_o <= '0;
        else     rd_data_o <= mem[rd_addr_i];
    end

    assign armed_o      = wr_en;
    assign done_o       = (state_q == DONE);
    assign triggered_o  = triggered_q;
    assign trig_addr_o  = trig_addr_q;
    assign start_addr_o = start_addr_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core (DATA_W=8, DEPTH=16, PRE_TRIG=4): capture table
// plus hand sequences for reset, abort, collision and edge-trigger corners.
module tb_la_capture_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       arm;
    logic       abort;
    logic [7:0] mask;
    logic [7:0] value;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       armed;
    logic       triggered;
    logic       done;
    logic [3:0] trig_addr;
    logic [3:0] start_addr;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [3:0] last_trig;

`ifdef LA_EDGE_TRIG_EN
    localparam bit LEVEL = 1'b0;
`else
    localparam bit LEVEL = 1'b1;
`endif

    typedef struct {
        logic [7:0] mask;
        logic [7:0] value;
        logic [7:0] base;
        logic [7:0] stp;
        int         kt;
        logic [3:0] trig;
        logic [3:0] start;
        int         re_arm_k;
        bit         hit;
    } cap_vec_t;

    cap_vec_t vecs[6];

    la_capture_core #(.DATA_W(8), .DEPTH(16), .PRE_TRIG(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data),
        .arm_i        (arm),
        .abort_i      (abort),
        .trig_mask_i  (mask),
        .trig_value_i (value),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .armed_o      (armed),
        .triggered_o  (triggered),
        .done_o       (done),
        .trig_addr_o  (trig_addr),
        .start_addr_o (start_addr)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arm, stream base+stp*k, then verify flags, addresses and the full readout.
    task automatic run_vec(input cap_vec_t v);
        int trig_k;
        int done_k;
        mask  = v.mask;
        value = v.value;
        arm   = 1'b1;
        data  = v.base;
        step();
        arm = 1'b0;
        check("armed_after_arm", armed, 1);
        trig_k = -1;
        done_k = -1;
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            data = 8'(v.base + v.stp * k);
            arm  = (k == v.re_arm_k);
            step();
            arm = 1'b0;
            if (trig_k < 0 && triggered) trig_k = k;
            if (done) done_k = k;
        end
        if (v.hit) begin
            check("trig_cycle", trig_k, v.kt);
            check("done_cycle", done_k, v.kt + 11);
            check("trig_addr", trig_addr, v.trig);
            check("start_addr", start_addr, v.start);
            check("armed_at_done", armed, 0);
            check("triggered_at_done", triggered, 1);
            for (int i = 0; i < 16; i++) exp_q.push_back(8'(v.base + v.stp * (v.kt - 4 + i)));
            for (int i = 0; i < 16; i++) begin
                rd_addr = v.start + 4'(i);
                step();
                check("readout", rd_data, exp_q.pop_front());
            end
            last_trig = v.trig;
        end else begin
            check("no_trigger", trig_k, -1);
            check("still_armed", armed, 1);
            check("trig_addr_held", trig_addr, last_trig);
            abort = 1'b1;
            step();
            abort = 1'b0;
            check("armed_after_abort", armed, 0);
        end
    endtask

    initial begin
        int trig_k;

        vecs[0] = '{8'hFF, 8'h0A, 8'h00, 8'h01, 10, 4'd10, 4'd6,  -1, 1'b1};
        vecs[1] = '{8'hFF, 8'h0A, 8'h0A, 8'h00, 4,  4'd4,  4'd0,  -1, LEVEL};
        vecs[2] = '{8'h00, 8'h5A, 8'h55, 8'h03, 4,  4'd4,  4'd0,  -1, LEVEL};
        vecs[3] = '{8'h0F, 8'h07, 8'h10, 8'h01, 7,  4'd7,  4'd3,  -1, 1'b1};
        vecs[4] = '{8'hFF, 8'h13, 8'h00, 8'h01, 19, 4'd3,  4'd15, -1, 1'b1};
        vecs[5] = '{8'hFF, 8'h0A, 8'h00, 8'h01, 10, 4'd10, 4'd6,   6, 1'b1};

        rst = 1'b1; data = '0; arm = 1'b0; abort = 1'b0;
        mask = '0; value = '0; rd_addr = '0; last_trig = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_armed", armed, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_start_addr", start_addr, 0);
        check("rst_rd_data", rd_data, 0);

        for (int r = 0; r < 6; r++) run_vec(vecs[r]);

        // Read-before-write: addr 0 holds 0x10 from the last capture.
        arm = 1'b1;
        step();
        arm     = 1'b0;
        data    = 8'h80;
        rd_addr = 4'd0;
        step();
        check("rbw_old", rd_data, 8'h10);
        data = 8'h81;
        step();
        check("rbw_new", rd_data, 8'h80);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Abort mid-POST, then a clean re-capture.
        mask  = 8'hFF;
        value = 8'h0A;
        arm   = 1'b1;
        step();
        arm    = 1'b0;
        trig_k = -1;
        for (int k = 0; k < 30 && trig_k < 0; k++) begin
            data = 8'(k);
            step();
            if (triggered) trig_k = k;
        end
        check("abort_trig_cycle", trig_k, 10);
        data = 8'h0B;
        step();
        data = 8'h0C;
        step();
        check("post_armed", armed, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_armed", armed, 0);
        check("abort_triggered", triggered, 0);
        check("abort_done", done, 0);
        check("abort_trig_addr_held", trig_addr, 10);
        for (int k = 0; k < 20; k++) step();
        check("abort_done_stays_0", done, 0);
        run_vec(vecs[0]);

        // Abort wins over arm.
        abort = 1'b1;
        step();
        arm = 1'b1;
        step();
        arm   = 1'b0;
        abort = 1'b0;
        check("abort_priority_armed", armed, 0);
        step();
        check("abort_priority_armed_later", armed, 0);

        // Reset mid-POST with arm held high.
        arm = 1'b1;
        step();
        arm    = 1'b0;
        trig_k = -1;
        for (int k = 0; k < 30 && trig_k < 0; k++) begin
            data = 8'(k);
            step();
            if (triggered) trig_k = k;
        end
        step();
        step();
        rst = 1'b1;
        arm = 1'b1;
        step();
        step();
        check("midpost_rst_armed", armed, 0);
        check("midpost_rst_triggered", triggered, 0);
        check("midpost_rst_done", done, 0);
        check("midpost_rst_trig_addr", trig_addr, 0);
        check("midpost_rst_start_addr", start_addr, 0);
        check("midpost_rst_rd_data", rd_data, 0);
        rst = 1'b0;
        arm = 1'b0;
        step();
        check("after_rst_idle", armed, 0);

`ifdef LA_EDGE_TRIG_EN
        // Held match never fires; a 0x00 -> 0x0A rise does.
        mask  = 8'hFF;
        value = 8'h0A;
        data  = 8'h0A;
        arm   = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 0; k < 20; k++) step();
        check("edge_held_no_trig", triggered, 0);
        data = 8'h00;
        step();
        data = 8'h0A;
        step();
        check("edge_rise_trig", triggered, 1);
        check("edge_trig_addr", trig_addr, 5);
        check("edge_start_addr", start_addr, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
